// File: rtl/jtag_dtm_pkg.sv
// Shared encodings for the JTAG TAP / DMI transport: TAP states, IR codes, DMI op codes
// and the IEEE 1149.1 next-state rule.
package jtag_dtm_pkg;

  localparam int DMI_W = 40;

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET, RUN_TEST_IDLE,
    SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR,
    SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR
  } tap_state_e;

  localparam logic [4:0] IR_IDCODE = 5'h01;
  localparam logic [4:0] IR_DTMCS  = 5'h10;
  localparam logic [4:0] IR_DMI    = 5'h11;
  localparam logic [4:0] IR_BYPASS = 5'h1f;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;
  localparam logic [1:0] OP_BUSY  = 2'd3;

  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    tap_state_e n;
    case (s)
      TEST_LOGIC_RESET: n = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
      RUN_TEST_IDLE:    n = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_DR:        n = tms ? SELECT_IR : CAPTURE_DR;
      CAPTURE_DR:       n = tms ? EXIT1_DR  : SHIFT_DR;
      SHIFT_DR:         n = tms ? EXIT1_DR  : SHIFT_DR;
      EXIT1_DR:         n = tms ? UPDATE_DR : PAUSE_DR;
      PAUSE_DR:         n = tms ? EXIT2_DR  : PAUSE_DR;
      EXIT2_DR:         n = tms ? UPDATE_DR : SHIFT_DR;
      UPDATE_DR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
      SELECT_IR:        n = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
      CAPTURE_IR:       n = tms ? EXIT1_IR  : SHIFT_IR;
      SHIFT_IR:         n = tms ? EXIT1_IR  : SHIFT_IR;
      EXIT1_IR:         n = tms ? UPDATE_IR : PAUSE_IR;
      PAUSE_IR:         n = tms ? EXIT2_IR  : PAUSE_IR;
      EXIT2_IR:         n = tms ? UPDATE_IR : SHIFT_IR;
      UPDATE_IR:        n = tms ? SELECT_DR : RUN_TEST_IDLE;
      default:          n = TEST_LOGIC_RESET;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jtag_dtm_tap_pin_sync.sv
// Oversamples the JTAG pins into the clk domain and turns TCK edges into one-clk pulses.
module jtag_pin_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic tck_i,
  input  logic tms_i,
  input  logic tdi_i,
  output logic tck_rise_o,
  output logic tck_fall_o,
  output logic tms_o,
  output logic tdi_o
);

  logic [2:0] tck_q;
  logic [1:0] tms_q;
  logic [1:0] tdi_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tck_q <= '0;
      tms_q <= '0;
      tdi_q <= '0;
    end else begin
      tck_q <= {tck_q[1:0], tck_i};
      tms_q <= {tms_q[0], tms_i};
      tdi_q <= {tdi_q[0], tdi_i};
    end
  end

  // Third TCK stage only exists to detect edges on the already-synchronised value.
  assign tck_rise_o =  tck_q[1] & ~tck_q[2];
  assign tck_fall_o = ~tck_q[1] &  tck_q[2];
  assign tms_o      = tms_q[1];
  assign tdi_o      = tdi_q[1];

endmodule

// File: rtl/jtag_dtm_tap.sv
// JTAG TAP plus RISC-V style DTM: IDCODE/DTMCS/DMI/BYPASS registers, with DMI updates
// turned into requests towards the debug module and its responses held for the next capture.
module jtag_dtm_tap
  import jtag_dtm_pkg::*;
#(
  parameter int          DMI_ADDR_BITS = 6,
  parameter int          DMI_DATA_BITS = 32,
  parameter int          DMI_OP_BITS   = 2,
  parameter int          IR_BITS       = 5,
  parameter logic [31:0] IDCODE_VAL    = 32'h1e200a6d
) (
  input  logic clk,
  input  logic rst,
  input  logic jtag_TCK,
  input  logic jtag_TMS,
  input  logic jtag_TDI,
  output logic jtag_TDO,
  output logic dtm_req_valid,
  input  logic dtm_req_ready,
  output logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dtm_req_data,
  input  logic dm_resp_valid,
  input  logic [DMI_ADDR_BITS+DMI_DATA_BITS+DMI_OP_BITS-1:0] dm_resp_data
);

  localparam int DW = DMI_ADDR_BITS + DMI_DATA_BITS + DMI_OP_BITS;
  localparam int SW = $clog2(DW);

  logic tck_rise, tck_fall, tms_s, tdi_s;

  jtag_pin_sync u_sync (
    .clk_i      (clk),
    .rst_ni     (rst),
    .tck_i      (jtag_TCK),
    .tms_i      (jtag_TMS),
    .tdi_i      (jtag_TDI),
    .tck_rise_o (tck_rise),
    .tck_fall_o (tck_fall),
    .tms_o      (tms_s),
    .tdi_o      (tdi_s)
  );

  tap_state_e         state_q;
  logic [IR_BITS-1:0] ir_q, ir_eff;
  logic [DW-1:0]      sr_q, sr_d, dr_capture, req_data_q, resp_q;
  logic [SW-1:0]      shift_msb;
  logic [31:0]        dtmcs;
  logic [1:0]         dmi_status;
  logic               tdo_q, req_valid_q, busy_q, sticky_q, busy_eff, dmi_op_valid;

  always_comb begin
    case (ir_q)
      IR_IDCODE, IR_DTMCS, IR_DMI: ir_eff = ir_q;
      default:                     ir_eff = IR_BYPASS;
    endcase
  end

  assign dmi_status   = (busy_q | sticky_q) ? OP_BUSY : resp_q[DMI_OP_BITS-1:0];
  assign dtmcs        = {14'b0, 2'b0, 1'b0, 3'd5, sticky_q ? 2'b11 : 2'b00,
                         6'(DMI_ADDR_BITS), 4'd1};
  assign dmi_op_valid = (sr_q[DMI_OP_BITS-1:0] == OP_READ) || (sr_q[DMI_OP_BITS-1:0] == OP_WRITE);
  // A response arriving in the same clk as an update frees the transport for it.
  assign busy_eff     = busy_q & ~dm_resp_valid;

  always_comb begin
    case (ir_eff)
      IR_IDCODE: dr_capture = DW'(IDCODE_VAL);
      IR_DTMCS:  dr_capture = DW'(dtmcs);
      IR_DMI:    dr_capture = {resp_q[DW-1:DMI_OP_BITS], dmi_status};
      default:   dr_capture = '0;
    endcase
  end

  always_comb begin
    if (state_q == SHIFT_IR) shift_msb = SW'(IR_BITS - 1);
    else begin
      case (ir_eff)
        IR_DMI:              shift_msb = SW'(DW - 1);
        IR_DTMCS, IR_IDCODE: shift_msb = SW'(31);
        default:             shift_msb = '0;
      endcase
    end
  end

  always_comb begin
    sr_d = sr_q;
    case (state_q)
      CAPTURE_IR: sr_d = DW'(1'b1);
      CAPTURE_DR: sr_d = dr_capture;
      SHIFT_IR, SHIFT_DR: begin
        sr_d            = sr_q >> 1;
        sr_d[shift_msb] = tdi_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= TEST_LOGIC_RESET;
      ir_q        <= IR_IDCODE;
      sr_q        <= '0;
      tdo_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_data_q  <= '0;
      resp_q      <= '0;
      busy_q      <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      if (req_valid_q && dtm_req_ready) req_valid_q <= 1'b0;
      if (dm_resp_valid && busy_q) begin
        resp_q <= dm_resp_data;
        busy_q <= 1'b0;
      end
      if (tck_rise) begin
        state_q <= tap_next(state_q, tms_s);
        sr_q    <= sr_d;
        case (state_q)
          UPDATE_IR: ir_q <= sr_q[IR_BITS-1:0];
          UPDATE_DR: begin
            if (ir_eff == IR_DMI && dmi_op_valid) begin
              if (!busy_eff && !sticky_q) begin
                req_data_q  <= sr_q;
                req_valid_q <= 1'b1;
                busy_q      <= 1'b1;
              end else begin
                sticky_q <= 1'b1;
              end
            end else if (ir_eff == IR_DTMCS) begin
              if (sr_q[17]) begin
                sticky_q    <= 1'b0;
                busy_q      <= 1'b0;
                req_valid_q <= 1'b0;
              end else if (sr_q[16]) begin
                sticky_q <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
      if (tck_fall && (state_q == SHIFT_IR || state_q == SHIFT_DR)) tdo_q <= sr_q[0];
      if (state_q == TEST_LOGIC_RESET) begin
        ir_q     <= IR_IDCODE;
        sticky_q <= 1'b0;
      end
    end
  end

  assign jtag_TDO      = tdo_q;
  assign dtm_req_valid = req_valid_q;
  assign dtm_req_data  = req_data_q;

endmodule
